main_memory_arbiter: RTL and testbench
======================================

Name: main_memory_arbiter

Overview:
- Shares the single main_memory port between two requesters: the CPU (fetch, load, store) and an external port (program loader / debug / DMA).
- Sits between the CPU's memory-control outputs and main_memory.
- Grants one access per cycle and returns read data with a registered one-cycle latency.
- Supports locked external bursts, an anti-starvation limit, and a stall output so the CPU stage sequencer can hold its current stage.

Parameters:
- ADDR_WIDTH, 32, address width of both ports and of memory.
- DATA_WIDTH, 32, data width.
- MAX_WAIT, 4, consecutive cycles the external port may be denied before it overrides CPU priority.
- MAX_BURST, 16, maximum granted beats in one locked external burst.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_gnt  out  1  CPU access presented to memory this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt.
- cpu_rvalid  out  1  CPU read data valid, one-cycle pulse.
- cpu_rdata  out  DATA_WIDTH  CPU read data.
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  external request, same meaning as the CPU signals.
- ext_last  in  1  marks the final beat of an external burst; tie to 1 for single accesses.
- ext_gnt, ext_rvalid, ext_rdata  out  1/1/DATA_WIDTH  external grant and read return.
- mem_raddr, mem_waddr  out  ADDR_WIDTH  to main_memory.
- mem_wdata  out  DATA_WIDTH  to main_memory.
- mem_wen  out  1  to main_memory.
- mem_rdata  in  DATA_WIDTH  main_memory combinational read data.

Behaviour:
- State: owner FSM {IDLE, EXT_LOCK}, wait_cnt (0..MAX_WAIT, saturating), beat_cnt (0..MAX_BURST), rvalid/rdata output registers.
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; both counters 0.
  - All rvalid and rdata registers 0; any pending rvalid is squashed.
  - Grants are forced 0, so mem_wen=0 and cpu_stall=0.
  - Reset mid-burst drops the lock.
- Grant is combinational from the current requests and the registered state. At most one grant per cycle.
- In IDLE:
  - Grant ext if ext_req & (~cpu_req | wait_cnt==MAX_WAIT).
  - Otherwise grant cpu if cpu_req.
  - An ext grant with ext_last=0 and MAX_BURST>1 moves to EXT_LOCK and sets beat_cnt=1.
- In EXT_LOCK:
  - Ext has absolute priority when ext_req=1.
  - If ext_req=0, cpu may be granted that cycle and the lock is kept.
  - Each ext grant increments beat_cnt.
  - Return to IDLE on an ext grant with ext_last=1, or on the grant that makes beat_cnt==MAX_BURST (forced release).
  - After a forced release, ext re-arbitrates like any new request.
- wait_cnt:
  - Increments when ext_req & ~ext_gnt; saturates at MAX_WAIT.
  - Clears on ext_gnt or ~ext_req.
- Memory drive:
  - Granted port's addr goes to both mem_raddr and mem_waddr.
  - mem_wdata = granted wdata.
  - mem_wen = gnt & we.
  - With no grant: addresses and data 0, mem_wen 0.
- Writes commit at the posedge ending the grant cycle.
- Reads:
  - mem_rdata is captured at the posedge ending the grant cycle.
  - The matching *_rvalid is 1 for exactly the next cycle, with *_rdata held until the next capture for that port.
  - Writes produce no rvalid.
  - Back-to-back reads give back-to-back rvalid pulses.
- Simultaneous ext write and cpu read to the same address: only one is granted. A read granted the cycle after a write returns the new data.
- Requesters must hold req, addr, we and wdata stable until gnt. The arbiter does not queue.

Decomposition:
- arch_defines.v gets the owner-state encodings `ARB_IDLE=1'b0 and `ARB_EXT_LOCK=1'b1, plus default `ARB_MAX_WAIT and `ARB_MAX_BURST.
- One sub-module, arb_sat_counter (parameter MAX; ports inc, clr, out, at_max; active-low async reset), instantiated for wait_cnt and beat_cnt.

Test Plan:
- Reset mid-burst:
  - Stimulus: rst=0 during beat 3 of an EXT_LOCK burst, with a read pending.
  - Response: next cycle all gnt/rvalid/mem_wen are 0. After release, cpu_req alone gets cpu_gnt in the first cycle.
- CPU-only read:
  - Stimulus: cpu read of addr 0x10, mem holds 0xDEADBEEF.
  - Response: cpu_gnt in cycle 0; cpu_rvalid=1 with cpu_rdata=0xDEADBEEF in cycle 1 only; cpu_stall=0.
- Starvation override (MAX_WAIT=4):
  - Stimulus: cpu_req and ext_req both held high continuously.
  - Response: cpu granted cycles 0–3; ext granted cycle 4 while cpu_stall=1; wait_cnt returns to 0.
- Burst with ext_last:
  - Stimulus: ext burst of 3 writes to 0x100–0x102 (ext_last on beat 3), cpu_req high throughout.
  - Response: ext_gnt for 3 consecutive cycles, cpu_stall=1 for those cycles, cpu_gnt in cycle 3, and the memory holds all 3 words.
- Forced release (MAX_BURST=16):
  - Stimulus: ext_last never asserted.
  - Response: release after beat 16; cpu (requesting) is granted on cycle 16.
- Lock gap:
  - Stimulus: in EXT_LOCK, ext_req drops for 1 cycle while cpu reads.
  - Response: cpu granted in the gap; ext resumes on the next cycle with the lock held, and beat_cnt is unchanged across the gap.

Source files
------------

// File: rtl/main_memory_arbiter_pkg.sv
// Shared types and defaults for the main-memory arbiter: owner-state encoding,
// default starvation / burst limits, and a counter-width helper.
package main_memory_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE     = 1'b0,
    ARB_EXT_LOCK = 1'b1
  } arb_state_e;

  localparam int ARB_MAX_WAIT  = 4;
  localparam int ARB_MAX_BURST = 16;

  // Bits needed to hold 0..max; never narrower than one bit.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_counter
  import main_memory_arbiter_pkg::*;
#(
  parameter int MAX = ARB_MAX_WAIT,
  parameter int W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] out,
  output logic         at_max
);

  assign at_max = (out == W'(MAX));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
    end else if (clr) begin
      out <= '0;
    end else if (inc && !at_max) begin
      out <= out + W'(1);
    end
  end

endmodule

// File: rtl/main_memory_arbiter.sv
// Two-port arbiter (CPU vs external loader/debug/DMA) in front of main_memory,
// with locked external bursts, a starvation override and registered read return.
module main_memory_arbiter
  import main_memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = ARB_MAX_WAIT,
  parameter int MAX_BURST  = ARB_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  input  logic                  ext_last,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int WW = cnt_width(MAX_WAIT);
  localparam int BW = cnt_width(MAX_BURST);

  arb_state_e    state_q, state_d;
  logic [WW-1:0] wait_cnt;
  logic          wait_at_max;
  logic [BW-1:0] beat_cnt;
  logic          beat_at_max;
  logic          ext_override;
  logic          last_beat;
  logic          start_lock;
  logic          lock_end;

  assign ext_override = (wait_cnt == WW'(MAX_WAIT));
  assign last_beat    = (beat_cnt == BW'(MAX_BURST - 1)) | beat_at_max;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ARB_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/case can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cpu_gnt    = 1'b0;
    ext_gnt    = 1'b0;
    start_lock = 1'b0;
    lock_end   = 1'b0;
    if (rst) begin
      case (state_q)
        ARB_IDLE: begin
          ext_gnt    = ext_req & (~cpu_req | ext_override);
          cpu_gnt    = cpu_req & ~ext_gnt;
          start_lock = ext_gnt & ~ext_last & (MAX_BURST > 1);
          if (start_lock) state_d = ARB_EXT_LOCK;
        end
        ARB_EXT_LOCK: begin
          // A gap in ext_req lends the cycle to the CPU without dropping the lock.
          ext_gnt  = ext_req;
          cpu_gnt  = cpu_req & ~ext_req;
          lock_end = ext_gnt & (ext_last | last_beat);
          if (lock_end) state_d = ARB_IDLE;
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt & rst;

  arb_sat_counter #(.MAX(MAX_WAIT), .W(WW)) u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (ext_req & ~ext_gnt & ~wait_at_max),
    .clr    (ext_gnt | ~ext_req),
    .out    (wait_cnt),
    .at_max (wait_at_max)
  );

  arb_sat_counter #(.MAX(MAX_BURST), .W(BW)) u_beat_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (ext_gnt & ~lock_end & (start_lock | (state_q == ARB_EXT_LOCK))),
    .clr    (lock_end),
    .out    (beat_cnt),
    .at_max (beat_at_max)
  );

  always_comb begin
    mem_raddr = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    if (ext_gnt) begin
      mem_raddr = ext_addr;
      mem_wdata = ext_wdata;
      mem_wen   = ext_we;
    end else if (cpu_gnt) begin
      mem_raddr = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wen   = cpu_we;
    end
  end

  assign mem_waddr = mem_raddr;

  // NOTE: the read-data registers are reset as well as the valids, so a port
  // never observes stale data from before reset, even with rvalid low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      ext_rvalid <= ext_gnt & ~ext_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= mem_rdata;
      if (ext_gnt && !ext_we) ext_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Directed self-checking bench for main_memory_arbiter with a small
// behavioural memory (combinational read, posedge write).
module tb_main_memory_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ext_req, ext_we, ext_last, ext_gnt, ext_rvalid;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_wen;

  logic [DW-1:0] mem [0:1023];

  int errors = 0;
  int checks = 0;

  main_memory_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_WAIT   (4),
    .MAX_BURST  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_last   (ext_last),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .mem_raddr  (mem_raddr),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory preloads a known pattern while reset is held; 0x10 holds 0xDEADBEEF.
  assign mem_rdata = mem[mem_raddr[9:0]];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 + i;
      mem[16] <= 32'hDEAD_BEEF;
    end else if (mem_wen) begin
      mem[mem_waddr[9:0]] <= mem_wdata;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0; ext_last = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    cpu_req = 1'b1; cpu_we = 1'b1; ext_req = 1'b1; ext_we = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL reset_cpu_gnt: got %b expected 0", cpu_gnt); end
    checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL reset_ext_gnt: got %b expected 0", ext_gnt); end
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL reset_mem_wen: got %b expected 0", mem_wen); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_cpu_stall: got %b expected 0", cpu_stall); end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_cpu_rvalid: got %b expected 0", cpu_rvalid); end
    checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL reset_ext_rvalid: got %b expected 0", ext_rvalid); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata: got %h expected 0", cpu_rdata); end
    checks++; if (ext_rdata !== 32'h0) begin errors++; $display("FAIL reset_ext_rdata: got %h expected 0", ext_rdata); end
    idle_inputs();
    #1 rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_addr = 32'h10;
    #4;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL cpu_read_gnt: got %b expected 1", cpu_gnt); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_read_stall: got %b expected 0", cpu_stall); end
    checks++; if (mem_raddr !== 32'h10) begin errors++; $display("FAIL cpu_read_raddr: got %h expected 10", mem_raddr); end
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL cpu_read_wen: got %b expected 0", mem_wen); end
    next_cycle();
    idle_inputs();
    #4;
    checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL cpu_read_rvalid: got %b expected 1", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cpu_read_rdata: got %h expected deadbeef", cpu_rdata); end
    next_cycle();
    #4;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_read_rvalid_pulse: got %b expected 0", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cpu_read_rdata_held: got %h expected deadbeef", cpu_rdata); end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic exp;
    cpu_req = 1'b1; cpu_addr = 32'h20;
    ext_req = 1'b1; ext_addr = 32'h30; ext_last = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #4;
      exp = (c == 4);
      checks++; if (ext_gnt !== exp) begin errors++; $display("FAIL starve_ext_gnt c%0d: got %b expected %b", c, ext_gnt, exp); end
      checks++; if (cpu_gnt !== !exp) begin errors++; $display("FAIL starve_cpu_gnt c%0d: got %b expected %b", c, cpu_gnt, !exp); end
      checks++; if (cpu_stall !== exp) begin errors++; $display("FAIL starve_cpu_stall c%0d: got %b expected %b", c, cpu_stall, exp); end
      if (c == 4) begin
        checks++; if (mem_raddr !== 32'h30) begin errors++; $display("FAIL starve_ext_raddr: got %h expected 30", mem_raddr); end
      end
      if (c == 5) begin
        checks++; if (dut.wait_cnt !== 3'd0) begin errors++; $display("FAIL starve_wait_clear: got %0d expected 0", dut.wait_cnt); end
        checks++; if (ext_rvalid !== 1'b1) begin errors++; $display("FAIL starve_ext_rvalid: got %b expected 1", ext_rvalid); end
        checks++; if (ext_rdata !== 32'hA000_0030) begin errors++; $display("FAIL starve_ext_rdata: got %h expected a0000030", ext_rdata); end
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_burst_last();
    logic exp;
    int beat = 0;
    cpu_req = 1'b1; cpu_addr = 32'h20;
    ext_we = 1'b1;
    for (int c = 0; c < 8; c++) begin
      ext_req   = (beat < 3);
      ext_addr  = 32'h100 + beat;
      ext_wdata = 32'h1111_1111 * (beat + 1);
      ext_last  = (beat == 2);
      #4;
      exp = (c >= 4 && c <= 6);
      checks++; if (ext_gnt !== exp) begin errors++; $display("FAIL burst_ext_gnt c%0d: got %b expected %b", c, ext_gnt, exp); end
      checks++; if (cpu_gnt !== !exp) begin errors++; $display("FAIL burst_cpu_gnt c%0d: got %b expected %b", c, cpu_gnt, !exp); end
      checks++; if (cpu_stall !== exp) begin errors++; $display("FAIL burst_cpu_stall c%0d: got %b expected %b", c, cpu_stall, exp); end
      checks++; if (mem_wen !== exp) begin errors++; $display("FAIL burst_mem_wen c%0d: got %b expected %b", c, mem_wen, exp); end
      if (exp) beat++;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[256 + i] !== 32'h1111_1111 * (i + 1)) begin
        errors++; $display("FAIL burst_mem_word %0d: got %h expected %h", i, mem[256 + i], 32'h1111_1111 * (i + 1));
      end
    end
  endtask

  task automatic test_forced_release();
    logic exp;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h40; ext_last = 1'b0;
    for (int c = 0; c < 17; c++) begin
      if (c == 1) begin cpu_req = 1'b1; cpu_addr = 32'h50; end
      #4;
      exp = (c < 16);
      checks++; if (ext_gnt !== exp) begin errors++; $display("FAIL forced_ext_gnt c%0d: got %b expected %b", c, ext_gnt, exp); end
      checks++; if (cpu_gnt !== (!exp && c > 0)) begin errors++; $display("FAIL forced_cpu_gnt c%0d: got %b expected %b", c, cpu_gnt, !exp); end
      if (c == 16) begin
        checks++; if (dut.beat_cnt !== 5'd0) begin errors++; $display("FAIL forced_beat_clear: got %0d expected 0", dut.beat_cnt); end
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_lock_gap();
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h60; ext_last = 1'b0;
    #4;
    checks++; if (ext_gnt !== 1'b1) begin errors++; $display("FAIL gap_beat1_gnt: got %b expected 1", ext_gnt); end
    next_cycle();
    ext_addr = 32'h61;
    #4;
    checks++; if (ext_gnt !== 1'b1) begin errors++; $display("FAIL gap_beat2_gnt: got %b expected 1", ext_gnt); end
    next_cycle();
    ext_req = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h10;
    #4;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL gap_cpu_gnt: got %b expected 1", cpu_gnt); end
    checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL gap_ext_gnt: got %b expected 0", ext_gnt); end
    checks++; if (dut.beat_cnt !== 5'd2) begin errors++; $display("FAIL gap_beat_cnt: got %0d expected 2", dut.beat_cnt); end
    next_cycle();
    ext_req = 1'b1; ext_addr = 32'h62; cpu_addr = 32'h20;
    #4;
    checks++; if (ext_gnt !== 1'b1) begin errors++; $display("FAIL gap_resume_gnt: got %b expected 1", ext_gnt); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL gap_resume_stall: got %b expected 1", cpu_stall); end
    checks++; if (dut.beat_cnt !== 5'd2) begin errors++; $display("FAIL gap_beat_kept: got %0d expected 2", dut.beat_cnt); end
    checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL gap_cpu_rvalid: got %b expected 1", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL gap_cpu_rdata: got %h expected deadbeef", cpu_rdata); end
    next_cycle();
    ext_addr = 32'h63; ext_last = 1'b1;
    #4;
    checks++; if (ext_gnt !== 1'b1) begin errors++; $display("FAIL gap_last_gnt: got %b expected 1", ext_gnt); end
    checks++; if (dut.beat_cnt !== 5'd3) begin errors++; $display("FAIL gap_beat3: got %0d expected 3", dut.beat_cnt); end
    checks++; if (ext_rdata !== 32'hA000_0062) begin errors++; $display("FAIL gap_ext_rdata: got %h expected a0000062", ext_rdata); end
    next_cycle();
    ext_addr = 32'h64;
    #4;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL gap_unlocked_cpu_gnt: got %b expected 1", cpu_gnt); end
    checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL gap_unlocked_ext_gnt: got %b expected 0", ext_gnt); end
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h70; ext_last = 1'b0;
    #4;
    checks++; if (ext_gnt !== 1'b1) begin errors++; $display("FAIL rstb_beat1_gnt: got %b expected 1", ext_gnt); end
    next_cycle();
    ext_addr = 32'h71; cpu_req = 1'b1; cpu_addr = 32'h20;
    #4;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rstb_beat2_stall: got %b expected 1", cpu_stall); end
    next_cycle();
    ext_addr = 32'h72;
    #1;
    checks++; if (ext_rvalid !== 1'b1) begin errors++; $display("FAIL rstb_pending_rvalid: got %b expected 1", ext_rvalid); end
    checks++; if (ext_gnt !== 1'b1) begin errors++; $display("FAIL rstb_beat3_gnt: got %b expected 1", ext_gnt); end
    #1 rst = 1'b0;
    #1;
    checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL rstb_ext_gnt: got %b expected 0", ext_gnt); end
    checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL rstb_cpu_gnt: got %b expected 0", cpu_gnt); end
    checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL rstb_ext_rvalid: got %b expected 0", ext_rvalid); end
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL rstb_mem_wen: got %b expected 0", mem_wen); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rstb_cpu_stall: got %b expected 0", cpu_stall); end
    checks++; if (ext_rdata !== 32'h0) begin errors++; $display("FAIL rstb_ext_rdata: got %h expected 0", ext_rdata); end
    @(posedge clk);
    #2;
    checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL rstb_hold_ext_gnt: got %b expected 0", ext_gnt); end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rstb_hold_cpu_rvalid: got %b expected 0", cpu_rvalid); end
    idle_inputs();
    cpu_req = 1'b1; cpu_addr = 32'h10;
    #1 rst = 1'b1;
    #1;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rstb_after_cpu_gnt: got %b expected 1", cpu_gnt); end
    checks++; if (dut.beat_cnt !== 5'd0) begin errors++; $display("FAIL rstb_after_beat: got %0d expected 0", dut.beat_cnt); end
    next_cycle();
    idle_inputs();
    #4;
    checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL rstb_after_rvalid: got %b expected 1", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rstb_after_rdata: got %h expected deadbeef", cpu_rdata); end
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_starvation();
    test_burst_last();
    test_forced_release();
    test_lock_gap();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
